// File: rtl/qed_dup_sequencer.sv
// qed_dup_sequencer: drives exec_dup for the QED front end.
// It tracks how many originals are recorded but not yet replayed, and uses
// the same insert/delete rules as the paired instruction cache. It forces
// replay when the cache fills, pulses qed_ready when a replay drains, and
// sets a sticky error if the cache's vld_out ever disagrees with the model.
module qed_dup_sequencer #(
    parameter int ICACHE_DEPTH = 128,
    parameter int FILL_LIMIT   = 127,
    parameter int CNT_W        = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IF_stall,
    input  logic [31:0]      ifu_qed_instruction,
    input  logic             qed_switch_req,
    input  logic             qic_vld,
    output logic             exec_dup,
    output logic             qed_ready,
    output logic [CNT_W-1:0] outstanding,
    output logic             qed_err
);

    typedef enum logic {
        ORIG = 1'b0,
        DUP  = 1'b1
    } state_t;

    // The ring keeps one slot empty, so "full" is one below the depth.
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ICACHE_DEPTH - 1);
    localparam logic [CNT_W-1:0] FILL_CNT = CNT_W'(FILL_LIMIT);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic             is_nop;
    logic             ins;
    logic             del;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ready_nxt;
    logic             err_nxt;

    // Only the opcode field matters for NOP detection.
    logic unused_instr_bits;
    assign unused_instr_bits = ^ifu_qed_instruction[31:7];

    // The phase register itself is the exec_dup output.
    assign exec_dup = (state == DUP);

    // Shadow of the cache's insert/delete rules, next-state and checker logic.
    always_comb begin
        state_nxt = state;
        ready_nxt = 1'b0;
        is_nop    = (ifu_qed_instruction[6:0] == 7'b1111111);
        ins       = ~rst & (state == ORIG) & ~is_nop & ~IF_stall
                    & (outstanding != FULL_CNT);
        del       = ~rst & (state == DUP) & (outstanding != '0) & ~IF_stall;
        cnt_nxt   = outstanding + CNT_W'(ins) - CNT_W'(del);
        err_nxt   = qed_err | (qic_vld != (ins | del));
        case (state)
            ORIG: begin
                // A request with nothing recorded is dropped, not remembered.
                if (~IF_stall && (qed_switch_req || (cnt_nxt >= FILL_CNT))
                    && (cnt_nxt != '0)) begin
                    state_nxt = DUP;
                end
            end
            DUP: begin
                // The last duplicate leaving the cache ends replay.
                if (del && (outstanding == ONE_CNT)) begin
                    state_nxt = ORIG;
                    ready_nxt = 1'b1;
                end
            end
            default: state_nxt = ORIG;
        endcase
    end

    // Register phase, count, ready pulse and sticky error; reset clears all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ORIG;
            qed_ready   <= 1'b0;
            outstanding <= '0;
            qed_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            qed_ready   <= ready_nxt;
            outstanding <= cnt_nxt;
            qed_err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_qed_dup_sequencer.sv
// Directed bench for qed_dup_sequencer: a default-parameter instance plus a
// FILL_LIMIT=4 instance sharing the same stimulus.
module tb_qed_dup_sequencer;

    localparam logic [31:0] NONOP = 32'h0000_0013;
    localparam logic [31:0] NOP   = 32'h0000_007F;

    logic        clk = 1'b0;
    logic        rst;
    logic        IF_stall;
    logic [31:0] ifu_qed_instruction;
    logic        qed_switch_req;
    logic        qic_vld;

    logic        exec_dup,  exec_dup4;
    logic        qed_ready, qed_ready4;
    logic [6:0]  outstanding, outstanding4;
    logic        qed_err,   qed_err4;

    int errors = 0;
    int checks = 0;

    qed_dup_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .IF_stall            (IF_stall),
        .ifu_qed_instruction (ifu_qed_instruction),
        .qed_switch_req      (qed_switch_req),
        .qic_vld             (qic_vld),
        .exec_dup            (exec_dup),
        .qed_ready           (qed_ready),
        .outstanding         (outstanding),
        .qed_err             (qed_err)
    );

    qed_dup_sequencer #(.FILL_LIMIT(4)) dut4 (
        .clk                 (clk),
        .rst                 (rst),
        .IF_stall            (IF_stall),
        .ifu_qed_instruction (ifu_qed_instruction),
        .qed_switch_req      (qed_switch_req),
        .qic_vld             (qic_vld),
        .exec_dup            (exec_dup4),
        .qed_ready           (qed_ready4),
        .outstanding         (outstanding4),
        .qed_err             (qed_err4)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then land 1 time unit after the rising edge.
    task automatic applyStimulus(input logic r, input logic stall,
                                 input logic [31:0] instr, input logic req,
                                 input logic vld);
        rst                 = r;
        IF_stall            = stall;
        ifu_qed_instruction = instr;
        qed_switch_req      = req;
        qic_vld             = vld;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Linear directed sequence.
    initial begin
        // Reset
        applyStimulus(1, 0, NOP, 0, 0);
        applyStimulus(1, 0, NOP, 0, 0);
        checkOutput("rst_dup",   exec_dup,    0);
        checkOutput("rst_ready", qed_ready,   0);
        checkOutput("rst_cnt",   outstanding, 0);
        checkOutput("rst_err",   qed_err,     0);

        // Three inserts, request, three drains
        applyStimulus(0, 0, NONOP, 0, 1);
        checkOutput("ins1_cnt", outstanding, 1);
        applyStimulus(0, 0, NONOP, 0, 1);
        checkOutput("ins2_cnt", outstanding, 2);
        applyStimulus(0, 0, NONOP, 0, 1);
        checkOutput("ins3_cnt", outstanding, 3);
        checkOutput("ins3_dup", exec_dup,    0);
        applyStimulus(0, 0, NOP, 1, 0);
        checkOutput("sw_dup", exec_dup,    1);
        checkOutput("sw_cnt", outstanding, 3);
        applyStimulus(0, 0, NONOP, 0, 1);
        checkOutput("drn1_cnt",   outstanding, 2);
        checkOutput("drn1_ready", qed_ready,   0);
        applyStimulus(0, 0, NONOP, 0, 1);
        checkOutput("drn2_cnt", outstanding, 1);
        applyStimulus(0, 0, NONOP, 0, 1);
        checkOutput("drn3_cnt",   outstanding, 0);
        checkOutput("drn3_dup",   exec_dup,    0);
        checkOutput("drn3_ready", qed_ready,   1);
        applyStimulus(0, 0, NOP, 0, 0);
        checkOutput("post_ready", qed_ready, 0);
        checkOutput("post_err",   qed_err,   0);

        // NOPs with a request at count 0 are ignored
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, NOP, 1, 0);
        checkOutput("nop_cnt",   outstanding, 0);
        checkOutput("nop_dup",   exec_dup,    0);
        checkOutput("nop_ready", qed_ready,   0);

        // Stall holds DUP with count 2
        applyStimulus(0, 0, NONOP, 0, 1);
        applyStimulus(0, 0, NONOP, 0, 1);
        applyStimulus(0, 0, NOP, 1, 0);
        checkOutput("st_dup0", exec_dup,    1);
        checkOutput("st_cnt0", outstanding, 2);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, NONOP, 1, 0);
        checkOutput("st_dup5", exec_dup,    1);
        checkOutput("st_cnt5", outstanding, 2);
        applyStimulus(0, 0, NONOP, 0, 1);
        checkOutput("st_drn1_cnt",   outstanding, 1);
        checkOutput("st_drn1_ready", qed_ready,   0);
        applyStimulus(0, 0, NONOP, 0, 1);
        checkOutput("st_drn2_cnt",   outstanding, 0);
        checkOutput("st_drn2_dup",   exec_dup,    0);
        checkOutput("st_drn2_ready", qed_ready,   1);

        // Reset during replay with count 5
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, NONOP, 0, 1);
        applyStimulus(0, 0, NOP, 1, 0);
        checkOutput("mr_dup", exec_dup,    1);
        checkOutput("mr_cnt", outstanding, 5);
        applyStimulus(1, 0, NONOP, 0, 0);
        checkOutput("mr_rst_dup",   exec_dup,    0);
        checkOutput("mr_rst_cnt",   outstanding, 0);
        checkOutput("mr_rst_ready", qed_ready,   0);
        checkOutput("mr_rst_err",   qed_err,     0);
        applyStimulus(0, 0, NOP, 0, 0);
        checkOutput("mr_post_ready", qed_ready, 0);
        checkOutput("mr_post_dup",   exec_dup,  0);

        // FILL_LIMIT=4 instance switches on the 4th insert's edge
        applyStimulus(0, 0, NONOP, 0, 1);
        applyStimulus(0, 0, NONOP, 0, 1);
        applyStimulus(0, 0, NONOP, 0, 1);
        checkOutput("f4_dup3", exec_dup4,    0);
        checkOutput("f4_cnt3", outstanding4, 3);
        applyStimulus(0, 0, NONOP, 0, 1);
        checkOutput("f4_dup4",  exec_dup4,    1);
        checkOutput("f4_cnt4",  outstanding4, 4);
        checkOutput("def_dup4", exec_dup,     0);
        checkOutput("def_cnt4", outstanding,  4);

        // Default limit: fill to 127
        applyStimulus(1, 0, NOP, 0, 0);
        for (int i = 0; i < 126; i++) applyStimulus(0, 0, NONOP, 0, 1);
        checkOutput("full_cnt126", outstanding, 126);
        checkOutput("full_dup126", exec_dup,    0);
        applyStimulus(0, 0, NONOP, 0, 1);
        checkOutput("full_cnt127", outstanding, 127);
        checkOutput("full_dup127", exec_dup,    1);
        applyStimulus(0, 0, NONOP, 0, 1);
        checkOutput("full_drn_cnt", outstanding, 126);
        checkOutput("full_err",     qed_err,     0);

        // Checker: vld low during a valid insert
        applyStimulus(1, 0, NOP, 0, 0);
        applyStimulus(0, 0, NONOP, 0, 0);
        checkOutput("err_set", qed_err,     1);
        checkOutput("err_cnt", outstanding, 1);
        applyStimulus(0, 0, NOP, 0, 0);
        applyStimulus(0, 0, NOP, 0, 0);
        checkOutput("err_sticky", qed_err, 1);
        applyStimulus(1, 0, NOP, 0, 0);
        checkOutput("err_clr", qed_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
